// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package alu_arb_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned OPC_WIDTH_DEF  = 6;
    localparam int unsigned NREQ_DEF       = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // ALU opcode encodings understood by the shared ALU
    localparam logic [OPC_WIDTH_DEF-1:0] ALU_SRL = 6'h02;
    localparam logic [OPC_WIDTH_DEF-1:0] ALU_SRA = 6'h03;
    localparam logic [OPC_WIDTH_DEF-1:0] ALU_ADD = 6'h20;
    localparam logic [OPC_WIDTH_DEF-1:0] ALU_SUB = 6'h22;
    localparam logic [OPC_WIDTH_DEF-1:0] ALU_AND = 6'h24;
    localparam logic [OPC_WIDTH_DEF-1:0] ALU_OR  = 6'h25;
    localparam logic [OPC_WIDTH_DEF-1:0] ALU_XOR = 6'h26;
    localparam logic [OPC_WIDTH_DEF-1:0] ALU_NOR = 6'h27;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester / ALU / response bus of the ALU arbiter.
// The arbiter connects through the slave modport; requesters and the ALU through master.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OPC_W  = 6,
    parameter int unsigned NREQ   = 2
);
    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ*DATA_W-1:0] i_req_a;
    logic [NREQ*DATA_W-1:0] i_req_b;
    logic [NREQ*OPC_W-1:0]  i_req_opc;
    logic [NREQ-1:0]        o_req_ready;
    logic [DATA_W-1:0]      o_alu_a;
    logic [DATA_W-1:0]      o_alu_b;
    logic [OPC_W-1:0]       o_alu_op;
    logic [DATA_W-1:0]      i_alu_result;
    logic [NREQ-1:0]        o_rsp_valid;
    logic [DATA_W-1:0]      o_rsp_data;
    logic [NREQ-1:0]        i_rsp_ready;
    logic                   o_busy;

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_req_opc, i_alu_result, i_rsp_ready,
        output o_req_ready, o_alu_a, o_alu_b, o_alu_op, o_rsp_valid, o_rsp_data, o_busy
    );

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_req_opc, i_alu_result, i_rsp_ready,
        input  o_req_ready, o_alu_a, o_alu_b, o_alu_op, o_rsp_valid, o_rsp_data, o_busy
    );

endinterface

// File: rtl/rr_select.sv
// Combinational requester picker: first valid request at or after the pointer, wrapping.
// With ALU_ARB_FIXED_PRIO_EN defined the pointer is ignored and index 0 always wins.
module rr_select #(
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W:0] pos;

`ifdef ALU_ARB_FIXED_PRIO_EN
    wire unused_ptr = ^ptr_i;
`endif

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            pos = (IDX_W+1)'(i);
`else
            pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(NREQ)) begin
                pos = pos - (IDX_W+1)'(NREQ);
            end
`endif
            if (!any_o && req_i[pos[IDX_W-1:0]]) begin
                any_o = 1'b1;
                idx_o = pos[IDX_W-1:0];
            end
        end
        gnt_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: grant, drive operands, wait, return result.
// Build option: ALU_ARB_FIXED_PRIO_EN (fixed priority, index 0 highest) instead of round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned OPC_WIDTH   = OPC_WIDTH_DEF,
    parameter int unsigned NREQ        = NREQ_DEF,
    parameter int unsigned ALU_LATENCY = 1
) (
    input logic          i_clock,
    input logic          i_reset,
    alu_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(ALU_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NREQ-1:0]       ready_q, ready_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPC_WIDTH-1:0]  alu_op_q, alu_op_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  busy_q, busy_d;

    logic [NREQ-1:0]  sel_gnt;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             rsp_ack;

    rr_select #(.NREQ(NREQ)) u_rr_select (
        .req_i (bus.i_req_valid),
        .ptr_i (rr_q),
        .gnt_o (sel_gnt),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    // Only the granted requester's ready can close the response
    assign rsp_ack = |(bus.i_rsp_ready & rsp_valid_q);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sel_any)             state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == CNT_LAST)   state_d = ST_RESP;
            ST_RESP: if (rsp_ack)             state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rr_d        = rr_q;
        gnt_idx_d   = gnt_idx_q;
        cnt_d       = cnt_q;
        ready_d     = '0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    ready_d   = sel_gnt;
                    gnt_idx_d = sel_idx;
                    cnt_d     = '0;
                    for (int unsigned n = 0; n < NREQ; n++) begin
                        if (sel_gnt[n]) begin
                            alu_a_d  = bus.i_req_a[n*DATA_WIDTH +: DATA_WIDTH];
                            alu_b_d  = bus.i_req_b[n*DATA_WIDTH +: DATA_WIDTH];
                            alu_op_d = bus.i_req_opc[n*OPC_WIDTH +: OPC_WIDTH];
                        end
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    rsp_data_d  = bus.i_alu_result;
                    rsp_valid_d = NREQ'(1) << gnt_idx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ack) begin
                    rsp_valid_d = '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    rr_d = (gnt_idx_q == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rr_q        <= '0;
            gnt_idx_q   <= '0;
            cnt_q       <= '0;
            ready_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            gnt_idx_q   <= gnt_idx_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.o_req_ready = ready_q;
    assign bus.o_alu_a     = alu_a_q;
    assign bus.o_alu_b     = alu_b_q;
    assign bus.o_alu_op    = alu_op_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LATENCY=1, one with ALU_LATENCY=3.
// Honours ALU_ARB_FIXED_PRIO_EN when choosing expected grant order.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    alu_arbiter_if #(.DATA_W(8), .OPC_W(6), .NREQ(2)) b1 ();
    alu_arbiter_if #(.DATA_W(8), .OPC_W(6), .NREQ(2)) b3 ();

    alu_arbiter #(.DATA_WIDTH(8), .OPC_WIDTH(6), .NREQ(2), .ALU_LATENCY(1)) dut1 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (b1)
    );

    alu_arbiter #(.DATA_WIDTH(8), .OPC_WIDTH(6), .NREQ(2), .ALU_LATENCY(3)) dut3 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (b3)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    // Single-cycle ALU for dut1, three-cycle pipelined ALU for dut3
    assign b1.i_alu_result = alu_f(b1.o_alu_a, b1.o_alu_b, b1.o_alu_op);

    logic [7:0] p1, p2;
    always_ff @(posedge clk) begin
        p1 <= alu_f(b3.o_alu_a, b3.o_alu_b, b3.o_alu_op);
        p2 <= p1;
    end
    assign b3.i_alu_result = p2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic set_req1(input int unsigned n, input logic [7:0] a, input logic [7:0] b,
                            input logic [5:0] op);
        b1.i_req_a[n*8 +: 8]   = a;
        b1.i_req_b[n*8 +: 8]   = b;
        b1.i_req_opc[n*6 +: 6] = op;
    endtask

    int unsigned g;

    initial begin
        rst = 1'b1;
        b1.i_req_valid = '0; b1.i_req_a = '0; b1.i_req_b = '0; b1.i_req_opc = '0;
        b1.i_rsp_ready = '0;
        b3.i_req_valid = '0; b3.i_req_a = '0; b3.i_req_b = '0; b3.i_req_opc = '0;
        b3.i_rsp_ready = '0;
        repeat (3) step();

        chk("rst_ready",     32'(b1.o_req_ready), 32'h0);
        chk("rst_alu_a",     32'(b1.o_alu_a),     32'h0);
        chk("rst_alu_op",    32'(b1.o_alu_op),    32'h0);
        chk("rst_rsp_valid", 32'(b1.o_rsp_valid), 32'h0);
        chk("rst_rsp_data",  32'(b1.o_rsp_data),  32'h0);
        chk("rst_busy",      32'(b1.o_busy),      32'h0);
        chk("rst_busy3",     32'(b3.o_busy),      32'h0);
        rst = 1'b0;

        // Single ADD from requester 0
        set_req1(0, 8'h05, 8'h03, ALU_ADD);
        b1.i_req_valid = 2'b01;
        step();
        chk("t1_ready",     32'(b1.o_req_ready), 32'h1);
        chk("t1_alu_a",     32'(b1.o_alu_a),     32'h05);
        chk("t1_alu_b",     32'(b1.o_alu_b),     32'h03);
        chk("t1_alu_op",    32'(b1.o_alu_op),    32'(ALU_ADD));
        chk("t1_busy",      32'(b1.o_busy),      32'h1);
        chk("t1_rsp_early", 32'(b1.o_rsp_valid), 32'h0);
        b1.i_req_valid = 2'b00;
        step();
        chk("t1_ready_pulse", 32'(b1.o_req_ready), 32'h0);
        chk("t1_rsp_valid",   32'(b1.o_rsp_valid), 32'h1);
        chk("t1_rsp_data",    32'(b1.o_rsp_data),  32'h08);
        step();
        chk("t1_rsp_hold",    32'(b1.o_rsp_valid), 32'h1);
        b1.i_rsp_ready = 2'b01;
        step();
        chk("t1_rsp_done",    32'(b1.o_rsp_valid), 32'h0);
        chk("t1_idle_busy",   32'(b1.o_busy),      32'h0);
        chk("t1_alu_hold",    32'(b1.o_alu_a),     32'h05);

        // Both requesters held, response ready already high
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req1(0, 8'h10, 8'h20, ALU_ADD);
        set_req1(1, 8'hF0, 8'h0F, ALU_OR);
        b1.i_req_valid = 2'b11;
        b1.i_rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = FIXED ? 0 : (k % 2);
            step();
            chk("t2_grant",     32'(b1.o_req_ready), 32'(2'(1) << g));
            chk("t2_alu_a",     32'(b1.o_alu_a),     (g == 1) ? 32'hF0 : 32'h10);
            step();
            chk("t2_rsp_valid", 32'(b1.o_rsp_valid), 32'(2'(1) << g));
            chk("t2_rsp_data",  32'(b1.o_rsp_data),  (g == 1) ? 32'hFF : 32'h30);
            chk("t2_no_ready",  32'(b1.o_req_ready), 32'h0);
            step();
            chk("t2_rsp_clear", 32'(b1.o_rsp_valid), 32'h0);
        end
        b1.i_req_valid = 2'b10;
        step();
        chk("t5_req1_grant", 32'(b1.o_req_ready), 32'h2);
        b1.i_req_valid = 2'b00;
        step();
        chk("t5_rsp_valid",  32'(b1.o_rsp_valid), 32'h2);
        chk("t5_rsp_data",   32'(b1.o_rsp_data),  32'hFF);
        step();
        chk("t5_rsp_clear",  32'(b1.o_rsp_valid), 32'h0);

        // Response backpressure with a second request pending
        set_req1(0, 8'h07, 8'h03, ALU_AND);
        b1.i_req_valid = 2'b01;
        b1.i_rsp_ready = 2'b00;
        step();
        chk("t3_ready0", 32'(b1.o_req_ready), 32'h1);
        set_req1(1, 8'h55, 8'h0F, ALU_XOR);
        b1.i_req_valid = 2'b10;
        step();
        chk("t3_rsp_valid", 32'(b1.o_rsp_valid), 32'h1);
        chk("t3_rsp_data",  32'(b1.o_rsp_data),  32'h03);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_bp_valid", 32'(b1.o_rsp_valid), 32'h1);
            chk("t3_bp_data",  32'(b1.o_rsp_data),  32'h03);
            chk("t3_bp_ready", 32'(b1.o_req_ready), 32'h0);
            chk("t3_bp_busy",  32'(b1.o_busy),      32'h1);
        end
        b1.i_rsp_ready = 2'b10;
        step();
        chk("t3_foreign_ack", 32'(b1.o_rsp_valid), 32'h1);
        b1.i_rsp_ready = 2'b01;
        step();
        chk("t3_ack_valid", 32'(b1.o_rsp_valid), 32'h0);
        chk("t3_ack_ready", 32'(b1.o_req_ready), 32'h0);
        step();
        chk("t3_ready1", 32'(b1.o_req_ready), 32'h2);
        b1.i_req_valid = 2'b00;
        step();
        chk("t3_rsp1_valid", 32'(b1.o_rsp_valid), 32'h2);
        chk("t3_rsp1_data",  32'(b1.o_rsp_data),  32'h5A);
        b1.i_rsp_ready = 2'b10;
        step();
        chk("t3_rsp1_clear", 32'(b1.o_rsp_valid), 32'h0);

        // Reset in the middle of a requester-1 transaction taken with pointer at 1
        b1.i_rsp_ready = 2'b11;
        set_req1(0, 8'h01, 8'h01, ALU_ADD);
        b1.i_req_valid = 2'b01;
        step();
        chk("t4_pre_ready", 32'(b1.o_req_ready), 32'h1);
        b1.i_req_valid = 2'b00;
        step();
        chk("t4_pre_data", 32'(b1.o_rsp_data), 32'h02);
        step();
        set_req1(1, 8'h09, 8'h04, ALU_SUB);
        b1.i_req_valid = 2'b10;
        step();
        chk("t4_exec_ready", 32'(b1.o_req_ready), 32'h2);
        chk("t4_exec_busy",  32'(b1.o_busy),      32'h1);
        rst = 1'b1;
        b1.i_req_valid = 2'b00;
        step();
        chk("t4_rst_ready",     32'(b1.o_req_ready), 32'h0);
        chk("t4_rst_alu_a",     32'(b1.o_alu_a),     32'h0);
        chk("t4_rst_alu_b",     32'(b1.o_alu_b),     32'h0);
        chk("t4_rst_alu_op",    32'(b1.o_alu_op),    32'h0);
        chk("t4_rst_rsp_valid", 32'(b1.o_rsp_valid), 32'h0);
        chk("t4_rst_rsp_data",  32'(b1.o_rsp_data),  32'h0);
        chk("t4_rst_busy",      32'(b1.o_busy),      32'h0);
        rst = 1'b0;
        step();
        step();
        chk("t4_no_rsp",  32'(b1.o_rsp_valid), 32'h0);
        chk("t4_no_busy", 32'(b1.o_busy),      32'h0);
        set_req1(0, 8'h02, 8'h02, ALU_ADD);
        b1.i_req_valid = 2'b11;
        step();
        chk("t4_ptr_zero", 32'(b1.o_req_ready), 32'h1);
        b1.i_req_valid = 2'b10;
        step();
        chk("t4_rsp0_valid", 32'(b1.o_rsp_valid), 32'h1);
        chk("t4_rsp0_data",  32'(b1.o_rsp_data),  32'h04);
        step();
        step();
        chk("t4_ready1", 32'(b1.o_req_ready), 32'h2);
        b1.i_req_valid = 2'b00;
        step();
        chk("t4_rsp1_valid", 32'(b1.o_rsp_valid), 32'h2);
        chk("t4_rsp1_data",  32'(b1.o_rsp_data),  32'h05);
        step();
        chk("t4_end_busy", 32'(b1.o_busy), 32'h0);

        // Three-cycle ALU: warm-up ADD, then SUB 0-1
        b3.i_rsp_ready = 2'b01;
        b3.i_req_a[7:0] = 8'h05; b3.i_req_b[7:0] = 8'h03; b3.i_req_opc[5:0] = ALU_ADD;
        b3.i_req_valid = 2'b01;
        step();
        chk("t6_add_ready", 32'(b3.o_req_ready), 32'h1);
        b3.i_req_valid = 2'b00;
        repeat (3) step();
        chk("t6_add_valid", 32'(b3.o_rsp_valid), 32'h1);
        chk("t6_add_data",  32'(b3.o_rsp_data),  32'h08);
        step();
        chk("t6_add_idle",  32'(b3.o_busy),      32'h0);
        b3.i_req_a[7:0] = 8'h00; b3.i_req_b[7:0] = 8'h01; b3.i_req_opc[5:0] = ALU_SUB;
        b3.i_req_valid = 2'b01;
        step();
        chk("t6_ready",   32'(b3.o_req_ready), 32'h1);
        chk("t6_busy_c1", 32'(b3.o_busy),      32'h1);
        chk("t6_rsp_c1",  32'(b3.o_rsp_valid), 32'h0);
        b3.i_req_valid = 2'b00;
        step();
        chk("t6_busy_c2", 32'(b3.o_busy),      32'h1);
        chk("t6_rsp_c2",  32'(b3.o_rsp_valid), 32'h0);
        step();
        chk("t6_busy_c3", 32'(b3.o_busy),      32'h1);
        chk("t6_rsp_c3",  32'(b3.o_rsp_valid), 32'h0);
        step();
        chk("t6_rsp_valid", 32'(b3.o_rsp_valid), 32'h1);
        chk("t6_rsp_data",  32'(b3.o_rsp_data),  32'hFF);
        chk("t6_busy_rsp",  32'(b3.o_busy),      32'h1);
        step();
        chk("t6_rsp_clear", 32'(b3.o_rsp_valid), 32'h0);
        chk("t6_busy_done", 32'(b3.o_busy),      32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
